rr_select_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the 6:1 nibble select datapath.
//   Up to N_REQ requesters each present a DATA_W-bit word plus a request.
//   The block picks one requester fairly, drives the select code, and forwards
//   the chosen word on a registered valid/ready output.
//   It holds a grant for up to BURST accepted beats, then rotates priority.

---
 rtl/rr_select_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_select_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter/sequencer for the nibble select datapath: picks one requester,
// holds the grant for up to BURST accepted beats, then rotates priority past it.
module rr_select_arbiter #(
  parameter int N_REQ  = 6,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int BURST  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          sel,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy
);

  localparam int CNT_W = (BURST < 2) ? 1 : $clog2(BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               valid_reg, valid_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [DATA_W-1:0]  words [N_REQ];
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   scan_idx;
  logic               accept;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign words[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = SEL_W'((int'(ptr_reg) + k) % N_REQ);
      if (req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign accept = (state_reg == BUSY) && valid_reg && out_ready;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    gnt_next   = gnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = BUSY;
          sel_next   = pick_idx;
          gnt_next   = N_REQ'(1) << pick_idx;
          data_next  = words[pick_idx];
          valid_next = 1'b1;
          cnt_next   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (accept) begin
          if (req[sel_reg] && (cnt_reg < CNT_W'(BURST))) begin
            data_next = words[sel_reg];
            cnt_next  = cnt_reg + CNT_W'(1);
          end else begin
            // sel is left alone so it still names the last granted requester.
            state_next = IDLE;
            valid_next = 1'b0;
            gnt_next   = '0;
            ptr_next   = (sel_reg == SEL_W'(N_REQ - 1)) ? '0 : sel_reg + SEL_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      gnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A beat caught by reset is discarded, so the handshake pulse is suppressed too.
  assign ack       = (accept && !rst) ? gnt_reg : '0;
  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign sel       = sel_reg;
  assign gnt       = gnt_reg;
  assign busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: a grant/burst model checked every cycle,
// plus literal expectations for each scenario.
module tb_rr_select_arbiter;
  localparam int N = 6;
  localparam int W = 4;
  localparam int SW = 3;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  sel;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;

  rr_select_arbiter #(.N_REQ(N), .DATA_W(W), .SEL_W(SW), .BURST(B)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: which requester holds the grant, how many beats it has had, and the word on offer.
  bit         m_busy = 1'b0;
  int         m_ptr  = 0;
  int         m_sel  = 0;
  int         m_cnt  = 0;
  logic [W-1:0] m_data = '0;

  function automatic logic [W-1:0] word_of(input int i);
    return W'(data_in >> (i * W));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_ptr <= 0; m_sel <= 0; m_cnt <= 0; m_data <= '0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_busy <= 1'b1;
        m_sel  <= rr_pick(req, m_ptr);
        m_data <= word_of(rr_pick(req, m_ptr));
        m_cnt  <= 1;
      end
    end else if (out_ready) begin
      if (req[m_sel] && m_cnt < B) begin
        m_data <= word_of(m_sel);
        m_cnt  <= m_cnt + 1;
      end else begin
        m_busy <= 1'b0;
        m_ptr  <= (m_sel + 1) % N;
      end
    end
  end

  int           grants[$];
  logic [W-1:0] beats[$];
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("busy", 32'(busy), 32'(m_busy));
      check("sel", 32'(sel), 32'(m_sel));
      check("gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
      check("out_data", 32'(out_data), 32'(m_data));
      check("ack", 32'(ack), (m_busy && out_ready && !rst) ? (32'd1 << m_sel) : 32'd0);
      if (gnt != '0 && prev_gnt == '0) grants.push_back(int'(sel));
      if (ack != '0) begin
        beats.push_back(out_data);
        $display("beat: requester %0d data %h ack %b", sel, out_data, ack);
      end
      prev_gnt = gnt;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  int exp_g[7] = '{0, 1, 2, 3, 4, 5, 0};
  logic [W-1:0] exp_b[4] = '{4'hA, 4'hA, 4'hB, 4'hB};

  initial begin
    rst = 1'b1; req = 6'h3F; out_ready = 1'b1;
    data_in = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    tick;
    chk_en = 1'b1;
    tick;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_ack", 32'(ack), 0);

    // Single requester: two beats, then priority moves to 3.
    rst = 1'b0; req = 6'b000100; beats.delete();
    tick;
    check("single_sel", 32'(sel), 2);
    check("single_data", 32'(out_data), 32'hC);
    check("single_ack1", 32'(ack), 32'b000100);
    tick;
    check("single_ack2", 32'(ack), 32'b000100);
    req = '0;
    tick;
    check("single_idle", 32'(out_valid), 0);
    check("single_beats", 32'(beats.size()), 2);
    req = 6'b001001;
    tick;
    check("ptr_after_single", 32'(sel), 3);
    req = '0;
    tick;
    check("ptr_idle", 32'(out_valid), 0);

    // Fairness with all requesters active.
    do_reset;
    req = 6'h3F; grants.delete(); beats.delete();
    repeat (21) tick;
    req = '0;
    tick;
    check("fair_count", 32'(grants.size() >= 7), 1);
    for (int k = 0; k < 7 && k < grants.size(); k++) check("fair_order", 32'(grants[k]), 32'(exp_g[k]));
    for (int k = 0; k < 4 && k < beats.size(); k++) check("fair_beats", 32'(beats[k]), 32'(exp_b[k]));

    // Pointer wrap 5 -> 0.
    do_reset;
    grants.delete();
    req = 6'b010000;
    tick; tick;
    req = 6'b100001;
    repeat (6) tick;
    req = '0;
    repeat (2) tick;
    check("wrap_count", 32'(grants.size()), 3);
    if (grants.size() == 3) begin
      check("wrap_g0", 32'(grants[0]), 4);
      check("wrap_g1", 32'(grants[1]), 5);
      check("wrap_g2", 32'(grants[2]), 0);
    end

    // Backpressure holds the beat with no ack.
    do_reset;
    out_ready = 1'b0; req = 6'b001000;
    tick;
    repeat (5) begin
      check("bp_data", 32'(out_data), 32'hD);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_ack", 32'(ack), 0);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ack", 32'(ack), 32'b001000);
    req = '0;
    tick;
    check("bp_done_valid", 32'(out_valid), 0);
    check("bp_done_ack", 32'(ack), 0);

    // Requester drops before its first beat is accepted.
    do_reset;
    out_ready = 1'b0; req = 6'b010000; beats.delete();
    tick;
    req = '0;
    tick;
    check("drop_valid", 32'(out_valid), 1);
    check("drop_data", 32'(out_data), 32'hE);
    out_ready = 1'b1;
    tick;
    check("drop_idle", 32'(out_valid), 0);
    check("drop_beats", 32'(beats.size()), 1);

    // Reset while a beat is pending.
    out_ready = 1'b0; req = 6'b000010;
    tick;
    check("rb_valid", 32'(out_valid), 1);
    check("rb_data", 32'(out_data), 32'hB);
    beats.delete();
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check("rb_ack", 32'(ack), 0);
    tick;
    check("rb_after", 32'(out_valid), 0);
    rst = 1'b0; req = '0;
    tick;
    check("rb_no_beat", 32'(beats.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
